// File: rtl/rv32_lsu_pkg.sv
// rtl/rv32_lsu_pkg.sv - shared funct3 codes, FSM state type and access sizing for the RV32I LSU
package rv32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIN,
        ERR
    } lsu_state_e;

    // Access width in bytes; 0 marks a funct3 with no defined width.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            F3_W:        size_bytes = 3'd4;
            default:     size_bytes = 3'd0;
        endcase
    endfunction

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            f3_legal = (size_bytes(funct3) != 3'd0);
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane shift/strobe generation and load extract/extend
module lsu_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] low_word,
    input  logic [23:0] high_word,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [3:0]  wstrb_lo,
    output logic [3:0]  wstrb_hi,
    output logic        split,
    output logic [31:0] rdata_ext
);

    logic [2:0]  n;
    logic [3:0]  span;
    logic [31:0] wdata_trim;
    logic [7:0]  mask_base;
    logic [7:0]  mask_wide;
    logic [63:0] wdata_wide;
    logic [31:0] rdata_word;

    always_comb begin
        n          = size_bytes(funct3);
        span       = {2'b00, offset} + {1'b0, n};
        split      = (span > 4'd4);
        wdata_trim = 32'h0;
        mask_base  = 8'h00;
        case (n)
            3'd1: begin wdata_trim = {24'h0, wdata[7:0]};  mask_base = 8'h01; end
            3'd2: begin wdata_trim = {16'h0, wdata[15:0]}; mask_base = 8'h03; end
            3'd4: begin wdata_trim = wdata;                mask_base = 8'h0F; end
            default: ;
        endcase
        wdata_wide = {32'h0, wdata_trim} << {offset, 3'b000};
        mask_wide  = mask_base << offset;
        wdata_lo   = wdata_wide[31:0];
        wdata_hi   = wdata_wide[63:32];
        wstrb_lo   = mask_wide[3:0];
        wstrb_hi   = mask_wide[7:4];

        // At most three bytes of the high word can ever contribute to a result.
        case (offset)
            2'd0:    rdata_word = low_word;
            2'd1:    rdata_word = {high_word[7:0],  low_word[31:8]};
            2'd2:    rdata_word = {high_word[15:0], low_word[31:16]};
            default: rdata_word = {high_word[23:0], low_word[31:24]};
        endcase

        case (funct3)
            F3_B:    rdata_ext = {{24{rdata_word[7]}}, rdata_word[7:0]};
            F3_H:    rdata_ext = {{16{rdata_word[15]}}, rdata_word[15:0]};
            F3_W:    rdata_ext = rdata_word;
            F3_BU:   rdata_ext = {24'h0, rdata_word[7:0]};
            F3_HU:   rdata_ext = {16'h0, rdata_word[15:0]};
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store initiator: transaction FSM, registers and memory handshake
module lsu_mem_ctrl
    import rv32_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   low_q;
    logic [23:0]       high_q;
    logic              rd_pend_q;
    logic              rd_hi_q;
    logic [XLEN-1:0]   resp_q;

    logic [XLEN-1:0]   wdata_lo, wdata_hi, rdata_ext, word_addr, resp_data;
    logic [STRB_W-1:0] wstrb_lo, wstrb_hi;
    logic              split;

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .low_word  (low_q),
        .high_word (high_q),
        .wdata_lo  (wdata_lo),
        .wdata_hi  (wdata_hi),
        .wstrb_lo  (wstrb_lo),
        .wstrb_hi  (wstrb_hi),
        .split     (split),
        .rdata_ext (rdata_ext)
    );

    assign word_addr = {addr_q[XLEN-1:2], 2'b00};
    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign resp_data = (state_q == FIN && !we_q) ? rdata_ext : '0;
    assign resp_rdata = resp_valid ? resp_data : resp_q;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = f3_legal(req_we, req_funct3) ? LO : ERR;
                end
            end
            LO: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = word_addr;
                mem_wdata = we_q ? wdata_lo : '0;
                mem_wstrb = we_q ? wstrb_lo : '0;
                if (mem_gnt) begin
                    state_d = split ? HI : FIN;
                end
            end
            HI: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = word_addr + 32'd4;
                mem_wdata = we_q ? wdata_hi : '0;
                mem_wstrb = we_q ? wstrb_hi : '0;
                if (mem_gnt) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // A load holds its response until the last read word is captured.
                if (!rd_pend_q) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            low_q     <= '0;
            high_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_hi_q   <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            rd_pend_q <= mem_req && mem_gnt && !mem_we;
            rd_hi_q   <= (state_q == HI);
            if (rd_pend_q) begin
                if (rd_hi_q) begin
                    high_q <= mem_rdata[23:0];
                end else begin
                    low_q <= mem_rdata;
                end
            end
            if (resp_valid) begin
                resp_q <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl against a word memory model
module tb_lsu_mem_ctrl;
    import rv32_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [8];
    int          beat_n;
    logic [31:0] blog_addr  [4];
    logic [31:0] blog_wdata [4];
    logic [3:0]  blog_strb  [4];
    logic        blog_we    [4];
    logic [31:0] snap_addr  [32];
    logic [31:0] snap_wdata [32];
    logic [3:0]  snap_strb  [32];
    logic        snap_req   [32];

    lsu_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory indexed by address bits [4:2], so 0xFFFFFFFC lands on word 7.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (beat_n < 4) begin
                blog_addr[beat_n]  = mem_addr;
                blog_wdata[beat_n] = mem_wdata;
                blog_strb[beat_n]  = mem_wstrb;
                blog_we[beat_n]    = mem_we;
            end
            beat_n = beat_n + 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr[4:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[4:2]];
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall_at, input int stall_len,
                          input bit noise, output int lat, output logic [31:0] rd, output logic er);
        int k;
        @(negedge clk);
        beat_n     = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k   = 0;
        lat = -1;
        rd  = 32'hDEAD_BEEF;
        er  = 1'bx;
        while (k < 30 && lat < 0) begin
            @(negedge clk);
            k++;
            mem_gnt = !(k >= stall_at && k < stall_at + stall_len);
            snap_addr[k]  = mem_addr;
            snap_wdata[k] = mem_wdata;
            snap_strb[k]  = mem_wstrb;
            snap_req[k]   = mem_req;
            if (noise) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_funct3 = F3_W;
                req_addr   = 32'h0000_0010;
                req_wdata  = 32'h0BAD_0BAD;
            end
            if (resp_valid) begin
                lat       = k;
                rd        = resp_rdata;
                er        = resp_err;
                req_valid = 1'b0;
            end
        end
        mem_gnt   = 1'b1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({req_ready, busy, resp_valid, resp_err, mem_req, mem_we} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000", {req_ready, busy, resp_valid, resp_err, mem_req, mem_we});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h strb=%b want all 0", resp_rdata, mem_addr, mem_wdata, mem_wstrb);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_byte_loads;
        logic [2:0]  f3  [3] = '{F3_B, F3_B, F3_BU};
        logic [31:0] adr [3] = '{32'h3, 32'h7, 32'h7};
        logic [31:0] exp [3] = '{32'h0000_0044, 32'hFFFF_FF88, 32'h0000_0088};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3[i], adr[i], 32'h0, 0, 0, 1'b0, lat, rd, er);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL byte_load_%0d: rdata=%h err=%b want %h err=0", i, rd, er, exp[i]);
            end
            checks++;
            if (lat !== 3 || beat_n !== 1 || blog_addr[0] !== {adr[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL byte_load_timing_%0d: lat=%0d beats=%0d addr=%h want 3/1/%h", i, lat, beat_n, blog_addr[0], {adr[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_split_loads;
        logic [2:0]  f3  [3] = '{F3_H, F3_W, F3_HU};
        logic [31:0] adr [3] = '{32'h3, 32'h1, 32'h3};
        logic [31:0] exp [3] = '{32'h0000_5544, 32'h5544_3322, 32'h0000_5544};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3[i], adr[i], 32'h0, 0, 0, 1'b0, lat, rd, er);
            checks++;
            if (rd !== exp[i]) begin
                errors++;
                $display("FAIL split_load_%0d: rdata=%h want %h", i, rd, exp[i]);
            end
            checks++;
            if (lat !== 4 || beat_n !== 2 || blog_addr[0] !== 32'h0 || blog_addr[1] !== 32'h4 || blog_strb[0] !== 4'h0) begin
                errors++;
                $display("FAIL split_load_beats_%0d: lat=%0d beats=%0d a0=%h a1=%h s0=%b want 4/2/0/4/0000", i, lat, beat_n, blog_addr[0], blog_addr[1], blog_strb[0]);
            end
        end
    endtask

    task automatic test_split_store;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, F3_W, 32'h1, 32'hEDCF_1254, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (lat !== 3 || beat_n !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL sw_split_resp: lat=%0d beats=%0d rdata=%h err=%b want 3/2/0/0", lat, beat_n, rd, er);
        end
        checks++;
        if (blog_addr[0] !== 32'h0 || blog_strb[0] !== 4'b1110 || blog_wdata[0] !== 32'hCF12_5400 || blog_we[0] !== 1'b1) begin
            errors++;
            $display("FAIL sw_beat0: addr=%h strb=%b wdata=%h we=%b want 0/1110/cf125400/1", blog_addr[0], blog_strb[0], blog_wdata[0], blog_we[0]);
        end
        checks++;
        if (blog_addr[1] !== 32'h4 || blog_strb[1] !== 4'b0001 || blog_wdata[1] !== 32'h0000_00ED) begin
            errors++;
            $display("FAIL sw_beat1: addr=%h strb=%b wdata=%h want 4/0001/000000ed", blog_addr[1], blog_strb[1], blog_wdata[1]);
        end
        do_req(1'b0, F3_W, 32'h1, 32'h0, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (rd !== 32'hEDCF_1254) begin
            errors++;
            $display("FAIL sw_readback: rdata=%h want edcf1254", rd);
        end
    endtask

    task automatic test_half_stores;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, F3_H, 32'h6, 32'hEDCF_1254, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (lat !== 2 || beat_n !== 1 || blog_addr[0] !== 32'h4 || blog_strb[0] !== 4'b1100 || blog_wdata[0] !== 32'h1254_0000) begin
            errors++;
            $display("FAIL sh_aligned: lat=%0d beats=%0d addr=%h strb=%b wdata=%h want 2/1/4/1100/12540000", lat, beat_n, blog_addr[0], blog_strb[0], blog_wdata[0]);
        end
        do_req(1'b1, F3_H, 32'h3, 32'hEDCF_1254, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (lat !== 3 || beat_n !== 2 || blog_strb[0] !== 4'b1000 || blog_wdata[0] !== 32'h5400_0000
            || blog_strb[1] !== 4'b0001 || blog_wdata[1] !== 32'h0000_0012) begin
            errors++;
            $display("FAIL sh_split: lat=%0d beats=%0d s0=%b w0=%h s1=%b w1=%h want 3/2/1000/54000000/0001/00000012", lat, beat_n, blog_strb[0], blog_wdata[0], blog_strb[1], blog_wdata[1]);
        end
    endtask

    task automatic test_stall;
        int lat; logic [31:0] rd; logic er;
        bit stable;
        do_req(1'b0, F3_W, 32'h2, 32'h0, 2, 3, 1'b0, lat, rd, er);
        checks++;
        if (lat !== 7 || rd !== 32'h6612_5412) begin
            errors++;
            $display("FAIL stall_resp: lat=%0d rdata=%h want 7/66125412", lat, rd);
        end
        stable = (snap_addr[2] === 32'h4) && snap_req[2];
        for (int k = 3; k <= 5; k++) begin
            if (snap_addr[k] !== snap_addr[2] || snap_wdata[k] !== snap_wdata[2]
                || snap_strb[k] !== snap_strb[2] || !snap_req[k]) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL stall_stable: addr k2..5=%h %h %h %h req=%b%b%b%b want 4 held with req", snap_addr[2], snap_addr[3], snap_addr[4], snap_addr[5], snap_req[2], snap_req[3], snap_req[4], snap_req[5]);
        end
    endtask

    task automatic test_error;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 3'd3, 32'h0, 32'h0, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || beat_n !== 0 || snap_req[1] !== 1'b0) begin
            errors++;
            $display("FAIL err_load: lat=%0d err=%b rdata=%h beats=%0d req=%b want 1/1/0/0/0", lat, er, rd, beat_n, snap_req[1]);
        end
        do_req(1'b1, F3_BU, 32'h0, 32'h0, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (lat !== 1 || er !== 1'b1 || beat_n !== 0) begin
            errors++;
            $display("FAIL err_store: lat=%0d err=%b beats=%0d want 1/1/0", lat, er, beat_n);
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (beat_n !== 2 || blog_addr[0] !== 32'hFFFF_FFFC || blog_addr[1] !== 32'h0 || lat !== 4) begin
            errors++;
            $display("FAIL wrap_beats: beats=%0d a0=%h a1=%h lat=%0d want 2/fffffffc/0/4", beat_n, blog_addr[0], blog_addr[1], lat);
        end
        checks++;
        if (rd !== 32'h5411_AABB) begin
            errors++;
            $display("FAIL wrap_data: rdata=%h want 5411aabb", rd);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_resp = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL rst_mid_pre: req=%b addr=%h want 1/4", mem_req, mem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: req=%b ready=%b busy=%b resp=%b want 0/1/0/0", mem_req, req_ready, busy, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid || mem_req) seen_resp = 1'b1;
        end
        checks++;
        if (seen_resp || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet: activity=%b ready=%b want 0/1", seen_resp, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, F3_W, 32'h1, 32'h1357_9BDF, 0, 0, 1'b1, lat, rd, er);
        repeat (3) @(negedge clk);
        checks++;
        if (lat !== 3 || beat_n !== 2 || req_ready !== 1'b1 || mem[4] !== 32'h0) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d beats=%0d ready=%b mem4=%h want 3/2/1/0", lat, beat_n, req_ready, mem[4]);
        end
        do_req(1'b0, F3_W, 32'h1, 32'h0, 0, 0, 1'b0, lat, rd, er);
        checks++;
        if (rd !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL busy_readback: rdata=%h want 13579bdf", rd);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b1;
        mem_rdata  = 32'h0;
        beat_n     = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[0] = 32'h4433_2211;
        mem[1] = 32'h8877_6655;
        mem[7] = 32'hAABB_CCDD;

        test_reset();
        test_byte_loads();
        test_split_loads();
        test_split_store();
        test_half_stores();
        test_stall();
        test_error();
        test_wrap();
        test_reset_mid();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
